// File: rtl/keypad_scan_beep.sv
// 4x4 matrix keypad scanner: rotates the active-low column drive, debounces rows,
// and reports accepted presses as a key code with a one-cycle strobe plus a beep flag.
module keypad_scan_beep #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [19:0] DEB_CNT  = 20'd500000,
    parameter logic [15:0] FLAG_LEN = 16'd2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       flag
);

    localparam int DIV_W  = $clog2(int'(SCAN_DIV));
    localparam int DEB_W  = $clog2(int'(DEB_CNT) + 1);
    localparam int FLAG_W = $clog2(int'(FLAG_LEN) + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 16'd1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 20'd1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = '1;
    localparam logic [FLAG_W-1:0] FLAG_INIT = FLAG_W'(FLAG_LEN);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t             state, state_next;
    logic [3:0]         row_meta, row_s, pattern;
    logic [DIV_W-1:0]   div_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [FLAG_W-1:0]  flag_cnt;
    logic [1:0]         col_idx;
    logic [1:0]         prio_row;
    logic               row_idle, match, deb_done, div_wrap, accept;

    assign row_idle = (row_s == 4'b1111);
    assign match    = (row_s == pattern);
    assign deb_done = (deb_cnt == DEB_LAST);
    assign div_wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN:      if (!row_idle) state_next = DEB_PRESS;
            DEB_PRESS: begin
                if (!match)        state_next = SCAN;
                else if (deb_done) state_next = HELD;
            end
            HELD:      if (row_idle) state_next = DEB_REL;
            DEB_REL: begin
                if (!row_idle)     state_next = HELD;
                else if (deb_done) state_next = SCAN;
            end
            default:   state_next = SCAN;
        endcase
    end

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        accept   = (state == DEB_PRESS) && match && deb_done;
        flag     = (flag_cnt != '0);
        col      = 4'b1111 ^ (4'b0001 << col_idx);
        prio_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!pattern[i]) prio_row = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta  <= 4'b1111;
            row_s     <= 4'b1111;
            pattern   <= 4'b1111;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            flag_cnt  <= '0;
            col_idx   <= 2'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            row_meta  <= row;
            row_s     <= row_meta;
            key_valid <= accept;

            if (accept) begin
                key_code <= {prio_row, col_idx};
                flag_cnt <= FLAG_INIT;
            end else if (flag_cnt != '0) begin
                flag_cnt <= flag_cnt - 1'b1;
            end

            case (state)
                SCAN: begin
                    if (!row_idle) begin
                        pattern <= row_s;
                        deb_cnt <= '0;
                    end else if (div_wrap) begin
                        div_cnt <= '0;
                        col_idx <= col_idx + 2'd1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!match) begin
                        div_cnt <= '0;
                    end else if (!deb_done && deb_cnt != DEB_MAX) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (row_idle) deb_cnt <= '0;
                end
                DEB_REL: begin
                    if (row_idle) begin
                        if (deb_done) begin
                            div_cnt <= '0;
                        end else if (deb_cnt != DEB_MAX) begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
